// File: rtl/aes_out_buffer_pkg.sv
// Shared types and constants for the AES output-side elastic buffer.
// out_packet_t is the record emitted by the AES last-round stage.
package aes_out_buffer_pkg;

  typedef struct packed {
    logic         valid;
    logic [127:0] data;
    logic         en_de;   // 1 = decrypt, 0 = encrypt
  } out_packet_t;

  localparam int OUT_BUF_DEPTH        = 4;
  localparam int OUT_BUF_AFULL_MARGIN = 2;
  localparam int OUT_ENTRY_W          = 129;

endpackage

// File: rtl/aes_out_buffer.sv
// Elastic FIFO behind the AES last round: non-stallable push side, valid/ready pop side,
// almost-full hint, sticky overflow flag and saturating encrypt/decrypt completion counters.
module aes_out_buffer
  import aes_out_buffer_pkg::*;
#(
  parameter int DEPTH        = OUT_BUF_DEPTH,
  parameter int AFULL_MARGIN = OUT_BUF_AFULL_MARGIN,
  parameter int CNT_W        = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  out_packet_t                data_in,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [127:0]               out_data,
  output logic                       out_en_de,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       almost_full,
  output logic                       overflow,
  input  logic                       clear_overflow,
  output logic [CNT_W-1:0]           enc_done_cnt,
  output logic [CNT_W-1:0]           dec_done_cnt
);

  localparam int PTR_W      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_BITS   = $clog2(DEPTH + 1);
  localparam int AF_LVL_INT = (DEPTH > AFULL_MARGIN) ? (DEPTH - AFULL_MARGIN) : 0;

  localparam logic [CNT_BITS-1:0] FULL_LVL = CNT_BITS'(DEPTH);
  localparam logic [CNT_BITS-1:0] AF_LVL   = CNT_BITS'(AF_LVL_INT);

  logic [OUT_ENTRY_W-1:0] mem_reg [DEPTH];
  logic [PTR_W-1:0]       wr_ptr_reg;
  logic [PTR_W-1:0]       rd_ptr_reg;
  logic [CNT_BITS-1:0]    count_reg;
  logic [CNT_BITS-1:0]    count_next;
  logic                   overflow_reg;
  logic [CNT_W-1:0]       enc_cnt_reg;
  logic [CNT_W-1:0]       dec_cnt_reg;

  logic full;
  logic pop;
  logic push;
  logic drop;

  // A pop in the same cycle frees a slot, so a full FIFO still accepts the push.
  always_comb begin
    full = (count_reg == FULL_LVL);
    pop  = (count_reg != '0) && out_ready;
    push = data_in.valid && (!full || pop);
    drop = data_in.valid && full && !pop;

    count_next = count_reg;
    case ({push, pop})
      2'b10:   count_next = count_reg + CNT_BITS'(1);
      2'b01:   count_next = count_reg - CNT_BITS'(1);
      default: count_next = count_reg;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_reg[i] <= '0;
      end
    end else if (push) begin
      mem_reg[wr_ptr_reg] <= {data_in.data, data_in.en_de};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      if (pop)  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      count_reg <= count_next;
    end
  end

  // Set has priority over clear so a drop in the clearing cycle is never missed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow_reg <= 1'b0;
    end else if (drop) begin
      overflow_reg <= 1'b1;
    end else if (clear_overflow) begin
      overflow_reg <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      enc_cnt_reg <= '0;
      dec_cnt_reg <= '0;
    end else if (push) begin
      if (!data_in.en_de && !(&enc_cnt_reg)) enc_cnt_reg <= enc_cnt_reg + CNT_W'(1);
      if (data_in.en_de && !(&dec_cnt_reg))  dec_cnt_reg <= dec_cnt_reg + CNT_W'(1);
    end
  end

  assign out_valid               = (count_reg != '0);
  assign {out_data, out_en_de}   = mem_reg[rd_ptr_reg];
  assign count                   = count_reg;
  assign almost_full             = (count_reg >= AF_LVL);
  assign overflow                = overflow_reg;
  assign enc_done_cnt            = enc_cnt_reg;
  assign dec_done_cnt            = dec_cnt_reg;

endmodule
